axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_slv_pkg.sv | 32 +++
 rtl/axi_burst_addr.sv | 30 +++
 rtl/axi_sram_slave.sv | 216 +++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared AXI slave codes, FSM state types and burst legality check.
// Optional WRAP burst support is enabled by defining AXI_SLV_WRAP_BURST_EN.
package axi_slv_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Only full 32-bit beats are supported; WRAP lengths must give a power-of-two window.
    function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len);
        logic ok;
`ifndef AXI_SLV_WRAP_BURST_EN
        logic unused_len;
        unused_len = ^len;
`endif
        ok = (burst == BURST_FIXED) || (burst == BURST_INCR);
`ifdef AXI_SLV_WRAP_BURST_EN
        if (burst == BURST_WRAP)
            ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`endif
        return ok && (size == 3'b010);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for FIXED/INCR bursts, plus WRAP when AXI_SLV_WRAP_BURST_EN is defined.
module axi_burst_addr
    import axi_slv_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  burst,
    input  logic [7:0]  len,
    output logic [31:0] next_addr
);

`ifdef AXI_SLV_WRAP_BURST_EN
    logic [31:0] wrap_mask;
    // Window of (len+1) words, aligned to its own size.
    assign wrap_mask = {22'd0, len, 2'b11};
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = addr + 32'd4;
        if (burst == BURST_FIXED)
            next_addr = addr;
`ifdef AXI_SLV_WRAP_BURST_EN
        else if (burst == BURST_WRAP)
            next_addr = (addr & ~wrap_mask) | ((addr + 32'd4) & wrap_mask);
`endif
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-style SRAM slave: independent single-outstanding write and read bursts.
// Define AXI_SLV_WRAP_BURST_EN to accept WRAP bursts.
module axi_sram_slave
    import axi_slv_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int ID_W      = 4
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    output logic [1:0]      w_state_dbg,
    output logic            r_state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and outputs hold while valid=1 and ready=0.
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [31:0] a);
        return a[31:AW+2] == '0;
    endfunction

    logic unused_wid;
    assign unused_wid = ^wid;

    w_state_t        w_state, w_next;
    logic [ID_W-1:0] w_id;
    logic [31:0]     w_addr, w_addr_next;
    logic [7:0]      w_len, w_cnt;
    logic [1:0]      w_burst;
    logic            w_bad, w_dec;
    logic            aw_hs, w_hs, b_hs, w_final, beat_mis, beat_oor, mem_we;

    assign awready     = (w_state == W_IDLE);
    assign wready      = (w_state == W_DATA);
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign b_hs        = bvalid && bready;
    assign w_final     = (w_cnt == w_len);
    assign beat_mis    = (wlast != w_final);
    assign beat_oor    = !in_range(w_addr);
    // Once a burst is flagged bad, no later beat of it reaches the array.
    assign mem_we      = w_hs && !w_bad && !beat_mis && !beat_oor;
    assign w_state_dbg = w_state;

    axi_burst_addr u_w_addr (.addr(w_addr), .burst(w_burst), .len(w_len), .next_addr(w_addr_next));

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_bad   <= 1'b0;
            w_dec   <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_bad   <= !burst_legal(awsize, awburst, awlen);
                w_dec   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= w_addr_next;
                w_cnt  <= w_cnt + 8'd1;
                w_bad  <= w_bad | beat_mis;
                w_dec  <= w_dec | beat_oor;
                if (w_final) begin
                    bvalid <= 1'b1;
                    bid    <= w_id;
                    bresp  <= (w_bad || beat_mis) ? RESP_SLVERR :
                              (w_dec || beat_oor) ? RESP_DECERR : RESP_OKAY;
                end
            end
            if (b_hs) bvalid <= 1'b0;
        end
    end

    // Array has no reset so its contents survive areset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[w_addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    r_state_t    r_state, r_next;
    logic [31:0] r_addr, beat_addr, r_addr_next, beat_rdata;
    logic [7:0]  r_len, r_cnt, beat_len;
    logic [1:0]  r_burst, beat_burst, beat_rresp;
    logic        r_bad, beat_bad, beat_r_oor, ar_hs, r_hs, r_load;

    assign arready     = (r_state == R_IDLE);
    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign r_load      = ar_hs || (r_hs && !rlast);
    assign r_state_dbg = r_state;

    // The beat being loaded comes from the AR channel when idle, else from the running address.
    assign beat_addr  = (r_state == R_IDLE) ? araddr  : r_addr;
    assign beat_burst = (r_state == R_IDLE) ? arburst : r_burst;
    assign beat_len   = (r_state == R_IDLE) ? arlen   : r_len;
    assign beat_bad   = (r_state == R_IDLE) ? !burst_legal(arsize, arburst, arlen) : r_bad;
    assign beat_r_oor = !in_range(beat_addr);
    assign beat_rdata = (beat_bad || beat_r_oor) ? 32'd0 : mem[beat_addr[AW+1:2]];
    assign beat_rresp = beat_bad ? RESP_SLVERR : (beat_r_oor ? RESP_DECERR : RESP_OKAY);

    axi_burst_addr u_r_addr (.addr(beat_addr), .burst(beat_burst), .len(beat_len),
                             .next_addr(r_addr_next));

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid     <= arid;
                r_len   <= arlen;
                r_burst <= arburst;
                r_bad   <= beat_bad;
                r_cnt   <= '0;
                rlast   <= (arlen == 8'd0);
            end else if (r_hs && !rlast) begin
                r_cnt <= r_cnt + 8'd1;
                rlast <= ((r_cnt + 8'd1) == r_len);
            end
            // Registered array read: a same-cycle write to this word is not yet visible.
            if (r_load) begin
                rdata  <= beat_rdata;
                rresp  <= beat_rresp;
                r_addr <= r_addr_next;
                rvalid <= 1'b1;
            end else if (r_hs) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: table of write/read bursts plus stall and reset sequences.
module tb_axi_sram_slave;
    import axi_slv_pkg::*;

    localparam int MEM_WORDS = 256;
    localparam int ID_W      = 4;
    localparam int LIMIT     = 50;
    localparam logic [2:0] SZ4 = 3'b010;

    typedef struct packed {
        logic             is_read;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [2:0]       size;
        logic [3:0]       strb;
        logic [31:0]      base;
        logic             bad_last;
        logic [1:0]       bresp;
        logic [3:0][31:0] rdata;
        logic [3:0][1:0]  rresp;
    } vec_t;

    logic            aclk, areset;
    logic [ID_W-1:0] awid, wid, bid, arid, rid;
    logic [31:0]     awaddr, wdata, araddr, rdata;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic [3:0]      wstrb;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [1:0]      w_state_dbg;
    logic            r_state_dbg;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];
    vec_t vecs[$];

    axi_sram_slave #(.MEM_WORDS(MEM_WORDS), .ID_W(ID_W)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    // Clock and reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk_w(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [1:0] burst, input logic [2:0] size,
                                  input logic [3:0] strb, input logic [31:0] base,
                                  input logic bad_last, input logic [1:0] bresp);
        vec_t v;
        v = '0;
        v.addr = addr; v.len = len; v.burst = burst; v.size = size;
        v.strb = strb; v.base = base; v.bad_last = bad_last; v.bresp = bresp;
        return v;
    endfunction

    function automatic vec_t mk_r(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [1:0] burst, input logic [2:0] size,
                                  input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [31:0] d3,
                                  input logic [1:0] r0, input logic [1:0] r1,
                                  input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v = '0;
        v.is_read = 1'b1;
        v.addr = addr; v.len = len; v.burst = burst; v.size = size;
        v.rdata[0] = d0; v.rdata[1] = d1; v.rdata[2] = d2; v.rdata[3] = d3;
        v.rresp[0] = r0; v.rresp[1] = r1; v.rresp[2] = r2; v.rresp[3] = r3;
        return v;
    endfunction

    // Driver: one write burst, then B checked while bready is held low for two cycles.
    task automatic w_burst(input vec_t v, input logic [ID_W-1:0] id);
        int n;
        awid = id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < LIMIT) begin @(negedge aclk); n++; end
        if (n >= LIMIT) check("aw_timeout", 1, 0);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(v.len); i++) begin
            wid = id; wdata = v.base + i; wstrb = v.strb;
            wlast = v.bad_last ? (i == 0) : (i == int'(v.len));
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < LIMIT) begin @(negedge aclk); n++; end
            if (n >= LIMIT) check("w_timeout", 1, 0);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < LIMIT) begin @(negedge aclk); n++; end
        if (n >= LIMIT) check("b_timeout", 1, 0);
        check("bresp", bresp, v.bresp);
        check("bid", bid, id);
        repeat (2) @(negedge aclk);
        check("b_hold", {bvalid, bresp, bid}, {1'b1, v.bresp, id});
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("b_done", bvalid, 0);
    endtask

    // Driver + scoreboard: one read burst; optional 5-cycle rready stall on one beat.
    task automatic r_burst(input vec_t v, input logic [ID_W-1:0] id, input int stall_beat);
        int n;
        logic [63:0] exp;
        logic [31:0] d0;
        logic        l0, stable;
        for (int i = 0; i <= int'(v.len); i++) exp_q.push_back({30'd0, v.rresp[i], v.rdata[i]});
        arid = id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < LIMIT) begin @(negedge aclk); n++; end
        if (n >= LIMIT) check("ar_timeout", 1, 0);
        @(negedge aclk);
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i <= int'(v.len); i++) begin
            n = 0;
            while (!rvalid && n < LIMIT) begin @(negedge aclk); n++; end
            if (n >= LIMIT) check("r_timeout", 1, 0);
            exp = exp_q.pop_front();
            check("r_beat", {30'd0, rresp, rdata}, exp);
            check("rlast", rlast, (i == int'(v.len)));
            check("rid", rid, id);
            if (i == stall_beat) begin
                rready = 1'b0;
                d0 = rdata; l0 = rlast; stable = 1'b1;
                repeat (5) begin
                    @(negedge aclk);
                    if (!(rvalid === 1'b1 && rdata === d0 && rlast === l0)) stable = 1'b0;
                end
                check("r_stall_hold", stable, 1);
                rready = 1'b1;
            end
            @(negedge aclk);
        end
        rready = 1'b0;
        check("r_done", rvalid, 0);
    endtask

    initial begin
        logic [31:0] ex100 [4];
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        vecs.push_back(mk_w(32'h100, 8'd3, BURST_INCR, SZ4, 4'hF, 32'hA0, 1'b0, RESP_OKAY));
        vecs.push_back(mk_r(32'h100, 8'd3, BURST_INCR, SZ4, 32'hA0, 32'hA1, 32'hA2, 32'hA3,
                            RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY));
        vecs.push_back(mk_w(32'h200, 8'd0, BURST_INCR, SZ4, 4'hF, 32'h11223344, 1'b0, RESP_OKAY));
        vecs.push_back(mk_w(32'h200, 8'd0, BURST_INCR, SZ4, 4'b0010, 32'h0000AB00, 1'b0, RESP_OKAY));
        vecs.push_back(mk_r(32'h200, 8'd0, BURST_INCR, SZ4, 32'h1122AB44, 0, 0, 0,
                            RESP_OKAY, 0, 0, 0));
        vecs.push_back(mk_w(32'h300, 8'd2, BURST_FIXED, SZ4, 4'hF, 32'hC0, 1'b0, RESP_OKAY));
        vecs.push_back(mk_r(32'h300, 8'd2, BURST_FIXED, SZ4, 32'hC2, 32'hC2, 32'hC2, 0,
                            RESP_OKAY, RESP_OKAY, RESP_OKAY, 0));
        vecs.push_back(mk_w(32'h040, 8'd1, BURST_INCR, SZ4, 4'hF, 32'hE0, 1'b0, RESP_OKAY));
        vecs.push_back(mk_w(32'h040, 8'd1, BURST_INCR, 3'b001, 4'hF, 32'hF0, 1'b0, RESP_SLVERR));
        vecs.push_back(mk_r(32'h040, 8'd1, BURST_INCR, 3'b001, 0, 0, 0, 0,
                            RESP_SLVERR, RESP_SLVERR, 0, 0));
        vecs.push_back(mk_w(32'h040, 8'd1, BURST_INCR, SZ4, 4'hF, 32'h50, 1'b1, RESP_SLVERR));
        vecs.push_back(mk_w(32'h040, 8'd0, 2'b11, SZ4, 4'hF, 32'h77, 1'b0, RESP_SLVERR));
        vecs.push_back(mk_r(32'h040, 8'd0, 2'b11, SZ4, 0, 0, 0, 0, RESP_SLVERR, 0, 0, 0));
        vecs.push_back(mk_r(32'h040, 8'd1, BURST_INCR, SZ4, 32'hE0, 32'hE1, 0, 0,
                            RESP_OKAY, RESP_OKAY, 0, 0));
        vecs.push_back(mk_w(32'h3FC, 8'd1, BURST_INCR, SZ4, 4'hF, 32'h90, 1'b0, RESP_DECERR));
        vecs.push_back(mk_r(32'h3FC, 8'd1, BURST_INCR, SZ4, 32'h90, 0, 0, 0,
                            RESP_OKAY, RESP_DECERR, 0, 0));
        vecs.push_back(mk_w(32'h180, 8'd3, BURST_INCR, SZ4, 4'hF, 32'h60, 1'b0, RESP_OKAY));
        vecs.push_back(mk_w(32'h108, 8'd2, BURST_WRAP, SZ4, 4'hF, 32'hD0, 1'b0, RESP_SLVERR));
`ifdef AXI_SLV_WRAP_BURST_EN
        vecs.push_back(mk_w(32'h108, 8'd3, BURST_WRAP, SZ4, 4'hF, 32'hB0, 1'b0, RESP_OKAY));
        vecs.push_back(mk_r(32'h108, 8'd3, BURST_WRAP, SZ4, 32'hB0, 32'hB1, 32'hB2, 32'hB3,
                            RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY));
        ex100[0] = 32'hB2; ex100[1] = 32'hB3; ex100[2] = 32'hB0; ex100[3] = 32'hB1;
`else
        vecs.push_back(mk_w(32'h108, 8'd3, BURST_WRAP, SZ4, 4'hF, 32'hB0, 1'b0, RESP_SLVERR));
        vecs.push_back(mk_r(32'h108, 8'd3, BURST_WRAP, SZ4, 0, 0, 0, 0,
                            RESP_SLVERR, RESP_SLVERR, RESP_SLVERR, RESP_SLVERR));
        ex100[0] = 32'hA0; ex100[1] = 32'hA1; ex100[2] = 32'hA2; ex100[3] = 32'hA3;
`endif

        repeat (3) @(negedge aclk);
        check("rst_ready", {awready, arready, wready}, 3'b110);
        check("rst_b", {bvalid, bresp, bid}, 0);
        check("rst_r", {rvalid, rlast, rresp, rid, rdata}, 0);
        check("rst_state", {w_state_dbg, r_state_dbg}, 0);
        areset = 1'b0;
        @(negedge aclk);

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].is_read) r_burst(vecs[k], ID_W'(k), -1);
            else                 w_burst(vecs[k], ID_W'(k));
        end

        // Stalled read of the 0x100 block, also showing the effect of the WRAP write.
        r_burst(mk_r(32'h100, 8'd3, BURST_INCR, SZ4, ex100[0], ex100[1], ex100[2], ex100[3],
                     RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY), 4'hA, 1);

        // Reset in the middle of a write burst after two of four beats.
        awid = 4'h5; awaddr = 32'h180; awlen = 8'd3; awsize = SZ4; awburst = BURST_INCR;
        awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'h70 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            check("mid_wready", wready, 1);
            @(negedge aclk);
        end
        wdata = 32'h72;
        areset = 1'b1;
        #1;
        check("mid_rst_out", {awready, wready, bvalid, w_state_dbg}, {3'b100, 2'b00});
        @(negedge aclk);
        areset = 1'b0;
        wdata = 32'h73; wlast = 1'b1;
        repeat (2) @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
        check("post_rst_idle", {awready, wready, bvalid}, 3'b100);
        r_burst(mk_r(32'h180, 8'd3, BURST_INCR, SZ4, 32'h70, 32'h71, 32'h62, 32'h63,
                     RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY), 4'h3, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
